// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared types and constants for the SDRAM byte port
// State encoding, lane write masks and the lane byte selector.
package sdram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } byte_port_state_t;

  // A set bit in the write mask protects that byte from being written.
  localparam logic [1:0] WM_LANE0 = 2'b10;
  localparam logic [1:0] WM_LANE1 = 2'b01;
  localparam logic [1:0] WM_NONE  = 2'b00;

  function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic lane);
    return lane ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/byte_port_cache.sv
// rtl/byte_port_cache.sv - one-word read cache (tag, data, valid) for the byte port
// Fill on read miss, byte-lane write-through on a tag match, flush beats fill.
module byte_port_cache #(
  parameter int WA = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_flush,
  input  logic [WA-1:0] i_lookup_addr,
  output logic          o_hit,
  output logic [15:0]   o_hit_data,
  input  logic          i_fill_en,
  input  logic          i_wr_en,
  input  logic [WA-1:0] i_upd_addr,
  input  logic [15:0]   i_fill_data,
  input  logic          i_wr_lane,
  input  logic [7:0]    i_wr_byte
);

  logic          r_valid;
  logic [WA-1:0] r_tag;
  logic [15:0]   r_data;
  logic          w_upd_match;

  assign o_hit       = r_valid && (r_tag == i_lookup_addr);
  assign o_hit_data  = r_data;
  assign w_upd_match = r_valid && (r_tag == i_upd_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else begin
      if (i_fill_en) begin
        r_tag  <= i_upd_addr;
        r_data <= i_fill_data;
      end else if (i_wr_en && w_upd_match) begin
        if (i_wr_lane) r_data[15:8] <= i_wr_byte;
        else           r_data[7:0]  <= i_wr_byte;
      end
      if (i_flush)        r_valid <= 1'b0;
      else if (i_fill_en) r_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/sdram_byte_port.sv
// rtl/sdram_byte_port.sv - byte-wide client adapter driving one 16-bit SDRAM channel
// Optional one-word read cache enabled by SDRAM_BYTE_PORT_CACHE_EN.
module sdram_byte_port
  import sdram_pkg::*;
#(
  parameter int ADDR_BITS = 25
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata,
  output logic                 ack,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 flush,
  output logic                 ram_req,
  output logic                 ram_we,
  output logic [ADDR_BITS-2:0] ram_address,
  output logic [15:0]          ram_data_write,
  output logic [1:0]           ram_wm,
  input  logic [15:0]          ram_data_read,
  input  logic                 ram_ack
);

  byte_port_state_t     r_state;
  logic                 r_lane;
  logic [7:0]           r_rdata;
  logic                 r_ack;
  logic                 r_busy;
  logic                 r_overrun;
  logic                 r_ram_req;
  logic                 r_ram_we;
  logic [ADDR_BITS-2:0] r_ram_address;
  logic [15:0]          r_ram_data_write;
  logic [1:0]           r_ram_wm;

  logic                 w_hit;
  logic [15:0]          w_hit_data;
  logic                 w_ram_done;

  assign w_ram_done = (r_state == WAIT) && ram_ack;

`ifdef SDRAM_BYTE_PORT_CACHE_EN
  logic w_cache_hit;

  byte_port_cache #(
    .WA(ADDR_BITS-1)
  ) u_cache (
    .clk           (clk),
    .reset         (reset),
    .i_flush       (flush),
    .i_lookup_addr (addr[ADDR_BITS-1:1]),
    .o_hit         (w_cache_hit),
    .o_hit_data    (w_hit_data),
    .i_fill_en     (w_ram_done && !r_ram_we),
    .i_wr_en       (w_ram_done && r_ram_we),
    .i_upd_addr    (r_ram_address),
    .i_fill_data   (ram_data_read),
    .i_wr_lane     (r_lane),
    .i_wr_byte     (r_ram_data_write[7:0])
  );

  // A flush in the request cycle must not let a stale word answer.
  assign w_hit = w_cache_hit && !we && !flush;
`else
  logic w_unused_flush;
  assign w_unused_flush = flush;
  assign w_hit          = 1'b0;
  assign w_hit_data     = 16'h0000;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= IDLE;
      r_lane           <= 1'b0;
      r_rdata          <= 8'h00;
      r_ack            <= 1'b0;
      r_busy           <= 1'b0;
      r_overrun        <= 1'b0;
      r_ram_req        <= 1'b0;
      r_ram_we         <= 1'b0;
      r_ram_address    <= '0;
      r_ram_data_write <= 16'h0000;
      r_ram_wm         <= WM_NONE;
    end else begin
      r_ack     <= 1'b0;
      r_ram_req <= 1'b0;
      if (req && r_busy) r_overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          if (req) begin
            r_lane           <= addr[0];
            r_ram_we         <= we;
            r_ram_address    <= addr[ADDR_BITS-1:1];
            r_ram_data_write <= {wdata, wdata};
            r_ram_wm         <= we ? (addr[0] ? WM_LANE1 : WM_LANE0) : WM_NONE;
            r_busy           <= 1'b1;
            if (w_hit) begin
              r_rdata <= lane_byte(w_hit_data, addr[0]);
              r_ack   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_ram_req <= 1'b1;
              r_state   <= ISSUE;
            end
          end
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          if (ram_ack) begin
            if (!r_ram_we) r_rdata <= lane_byte(ram_data_read, r_lane);
            r_ack   <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rdata          = r_rdata;
  assign ack            = r_ack;
  assign busy           = r_busy;
  assign overrun        = r_overrun;
  assign ram_req        = r_ram_req;
  assign ram_we         = r_ram_we;
  assign ram_address    = r_ram_address;
  assign ram_data_write = r_ram_data_write;
  assign ram_wm         = r_ram_wm;

endmodule

// File: tb/tb_sdram_byte_port.sv
// tb/tb_sdram_byte_port.sv - bench for sdram_byte_port with a behavioural SDRAM channel
// Works with and without SDRAM_BYTE_PORT_CACHE_EN.
module tb_sdram_byte_port;

`ifdef SDRAM_BYTE_PORT_CACHE_EN
  localparam int CACHE = 1;
`else
  localparam int CACHE = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [24:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        ack;
  logic        busy;
  logic        overrun;
  logic        flush = 1'b0;
  logic        ram_req;
  logic        ram_we;
  logic [23:0] ram_address;
  logic [15:0] ram_data_write;
  logic [1:0]  ram_wm;
  logic [15:0] ram_data_read = '0;
  logic        ram_ack = 1'b0;

  sdram_byte_port #(.ADDR_BITS(25)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .we             (we),
    .addr           (addr),
    .wdata          (wdata),
    .rdata          (rdata),
    .ack            (ack),
    .busy           (busy),
    .overrun        (overrun),
    .flush          (flush),
    .ram_req        (ram_req),
    .ram_we         (ram_we),
    .ram_address    (ram_address),
    .ram_data_write (ram_data_write),
    .ram_wm         (ram_wm),
    .ram_data_read  (ram_data_read),
    .ram_ack        (ram_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [24:0] a;
    logic [7:0]  d;
    logic [7:0]  rd;
    logic [1:0]  wm;
    int          nreq_c;
  } vec_t;

  vec_t vt[15];
  vec_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  // SDRAM channel model
  logic [15:0] mem [0:255];
  logic        mem_clr = 1'b1;
  int          m_lat = 0;
  logic        m_manual = 1'b0;
  logic        m_force = 1'b0;
  logic        m_pend = 1'b0;
  int          m_cnt = 0;
  logic [7:0]  m_a = '0;
  logic        m_w = 1'b0;
  logic [1:0]  m_m = '0;
  logic [15:0] m_d = '0;
  logic [23:0] m_last_addr = '0;
  logic [1:0]  m_last_wm = '0;
  logic        m_last_we = 1'b0;
  int          n_ram_req = 0;
  int          n_ram_ack = 0;
  int          n_ack = 0;
  int          tick = 0;
  int          t_ram_ack = -10;

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic [1:0] wm);
    return {wm[1] ? old[15:8] : nw[15:8], wm[0] ? old[7:0] : nw[7:0]};
  endfunction

  always @(posedge clk) begin
    tick = tick + 1;
    if (ram_ack) begin
      t_ram_ack = tick;
      n_ram_ack = n_ram_ack + 1;
    end
    if (ack) n_ack = n_ack + 1;
    ram_ack       <= 1'b0;
    ram_data_read <= 16'($urandom);
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      m_pend <= 1'b0;
    end else if (ram_req) begin
      n_ram_req   = n_ram_req + 1;
      m_last_addr = ram_address;
      m_last_wm   = ram_wm;
      m_last_we   = ram_we;
      m_a    <= ram_address[7:0];
      m_w    <= ram_we;
      m_m    <= ram_wm;
      m_d    <= ram_data_write;
      m_pend <= 1'b1;
      m_cnt  <= m_lat;
    end else if (m_pend && m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end else if (m_pend && (!m_manual || m_force)) begin
      m_pend  <= 1'b0;
      ram_ack <= 1'b1;
      if (m_w) mem[m_a] <= merge(mem[m_a], m_d, m_m);
      else     ram_data_read <= mem[m_a];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic access(input vec_t v);
    int   rq0;
    int   cyc;
    int   exp_n;
    vec_t e;
    exp_n = (CACHE != 0) ? v.nreq_c : 1;
    sb.push_back(v);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    rq0   = n_ram_req;
    req   = 1'b1;
    we    = v.w;
    addr  = v.a;
    wdata = v.d;
    @(negedge clk);
    req = 1'b0;
    cyc = 1;
    while (!ack && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    chk($sformatf("ack_seen@%0h", e.a), 32'(ack), 1);
    chk("busy_in_ack", 32'(busy), 1);
    if (!e.w) chk($sformatf("rdata@%0h", e.a), 32'(rdata), 32'(e.rd));
    chk($sformatf("ram_req_count@%0h", e.a), 32'(n_ram_req - rq0), 32'(exp_n));
    if (exp_n == 0) begin
      chk("hit_latency", 32'(cyc), 1);
    end else begin
      chk("ack_after_ram_ack", 32'(tick - t_ram_ack), 0);
      chk($sformatf("ram_wm@%0h", e.a), 32'(m_last_wm), 32'(e.wm));
      chk("ram_address", 32'(m_last_addr), 32'(e.a[24:1]));
      chk("ram_we", 32'(m_last_we), 32'(e.w));
    end
  endtask

  initial begin
    vec_t v;
    int   rq0;
    int   ak0;
    int   ra0;
    int   cyc;

    vt[0]  = '{1'b1, 25'h0000010,   8'hA5, 8'h00, 2'b10, 1};
    vt[1]  = '{1'b1, 25'h0000011,   8'h3C, 8'h00, 2'b01, 1};
    vt[2]  = '{1'b0, 25'h0000010,   8'h00, 8'hA5, 2'b00, 1};
    vt[3]  = '{1'b0, 25'h0000011,   8'h00, 8'h3C, 2'b00, 0};
    vt[4]  = '{1'b1, 25'h1FFFFFF,   8'h77, 8'h00, 2'b01, 1};
    vt[5]  = '{1'b0, 25'h1FFFFFE,   8'h00, 8'h00, 2'b00, 1};
    vt[6]  = '{1'b0, 25'h1FFFFFF,   8'h00, 8'h77, 2'b00, 0};
    vt[7]  = '{1'b1, 25'h0000031,   8'hC3, 8'h00, 2'b01, 1};
    vt[8]  = '{1'b1, 25'h0000020,   8'hEF, 8'h00, 2'b10, 1};
    vt[9]  = '{1'b1, 25'h0000021,   8'hBE, 8'h00, 2'b01, 1};
    vt[10] = '{1'b0, 25'h0000021,   8'h00, 8'hBE, 2'b00, 1};
    vt[11] = '{1'b0, 25'h0000020,   8'h00, 8'hEF, 2'b00, 0};
    vt[12] = '{1'b1, 25'h0000020,   8'h55, 8'h00, 2'b10, 1};
    vt[13] = '{1'b0, 25'h0000020,   8'h00, 8'h55, 2'b00, 0};
    vt[14] = '{1'b0, 25'h0000021,   8'h00, 8'hBE, 2'b00, 0};

    repeat (3) @(negedge clk);
    reset   = 1'b0;
    mem_clr = 1'b0;
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_ram_req", 32'(ram_req), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_address", 32'(ram_address), 0);
    chk("rst_ram_data_write", 32'(ram_data_write), 0);
    chk("rst_ram_wm", 32'(ram_wm), 0);

    for (int i = 0; i < 15; i++) begin
      m_lat = i % 4;
      access(vt[i]);
    end

    // flush forces the next read of the cached word back to SDRAM
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    v = '{1'b0, 25'h0000020, 8'h00, 8'h55, 2'b00, 1};
    access(v);

    // request during WAIT is dropped and flagged
    m_lat = 3;
    @(negedge clk);
    rq0 = n_ram_req;
    ak0 = n_ack;
    chk("overrun_pre", 32'(overrun), 0);
    req = 1'b1; we = 1'b0; addr = 25'h0000031;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 25'h0000031; wdata = 8'h99;
    @(negedge clk);
    req = 1'b0;
    chk("overrun_set", 32'(overrun), 1);
    cyc = 0;
    while (!ack && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("overrun_orig_ack", 32'(ack), 1);
    chk("overrun_orig_rdata", 32'(rdata), 32'h0C3);
    repeat (5) @(negedge clk);
    chk("overrun_ack_count", 32'(n_ack - ak0), 1);
    chk("overrun_ram_req_count", 32'(n_ram_req - rq0), 1);
    chk("overrun_sticky", 32'(overrun), 1);

    // reset while waiting on SDRAM, then a late ack from the channel
    m_lat    = 0;
    m_manual = 1'b1;
    rq0      = n_ram_req;
    req = 1'b1; we = 1'b0; addr = 25'h0000020;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("wait_busy", 32'(busy), 1);
    chk("wait_ram_req_count", 32'(n_ram_req - rq0), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ack", 32'(ack), 0);
    chk("midrst_rdata", 32'(rdata), 0);
    chk("midrst_overrun", 32'(overrun), 0);
    chk("midrst_ram_address", 32'(ram_address), 0);
    chk("midrst_ram_wm", 32'(ram_wm), 0);
    ak0 = n_ack;
    ra0 = n_ram_ack;
    m_force = 1'b1;
    @(negedge clk);
    m_force = 1'b0;
    repeat (4) @(negedge clk);
    chk("late_ram_ack_driven", 32'(n_ram_ack - ra0), 1);
    chk("late_ram_ack_no_ack", 32'(n_ack - ak0), 0);
    m_manual = 1'b0;
    v = '{1'b0, 25'h0000031, 8'h00, 8'hC3, 2'b00, 1};
    access(v);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_byte_port.md
# sdram_byte_port

Byte-wide client adapter that sits directly upstream of the SDRAM controller and drives one of its `sdram_bus` channels as master. It converts single-byte read/write requests (cartridge-side loaders and mappers) into 16-bit word accesses with the correct write mask. It returns the addressed byte on reads, and can optionally serve repeated reads from a one-word read cache without touching SDRAM.

## Interface
Parameters:
- `ADDR_BITS`, 25: client byte-address width. The word address is `ADDR_BITS-1` bits and must equal the channel's `ADDR_BITS`.

Ports:
- `clk`  in  1  system clock, same clock as the SDRAM controller
- `reset`  in  1  synchronous, active-high reset
- `req`  in  1  one-cycle request pulse; sampled only when `busy`=0
- `we`  in  1  1 = write, 0 = read; sampled with `req`
- `addr`  in  ADDR_BITS  byte address; sampled with `req`
- `wdata`  in  8  write byte; sampled with `req`
- `rdata`  out  8  read byte; valid in the `ack` cycle and held until the next `ack`
- `ack`  out  1  one-cycle completion pulse, for reads and writes
- `busy`  out  1  high from the cycle after an accepted `req` through the `ack` cycle
- `overrun`  out  1  sticky; set when `req`=1 while `busy`=1; cleared only by `reset`
- `flush`  in  1  invalidates the read cache; ignored when the cache is compiled out
- `ram`  sdram_bus master  ADDR_BITS-1 word channel: `req`, `we`, `address`, `data_write`, `wm`, `data_read`, `ack`

## Operation
Address and data mapping:
- Word address = `addr[ADDR_BITS-1:1]`; lane = `addr[0]`.
- Lane 0 maps to `data[7:0]`; lane 1 maps to `data[15:8]`.
- Write: `ram.data_write` = {wdata, wdata}; `ram.wm` = 2'b10 for lane 0 and 2'b01 for lane 1 (a 1 masks that byte).
- Read: `ram.wm` = 2'b00; `rdata` is the selected lane of `ram.data_read`.

State machine (`IDLE`, `ISSUE`, `WAIT`, `DONE`):
- `IDLE` + `req`: latch `we`/`addr`/`wdata`. A cache hit on a read goes to `DONE`; everything else goes to `ISSUE`.
- `ISSUE`: drive `ram.req`=1 for exactly this cycle, then go to `WAIT`.
- `WAIT`: stay until `ram.ack`=1. On `ram.ack`, capture the lane byte into `rdata` (reads only) and update the cache, then go to `DONE`.
- `DONE`: `ack`=1 for one cycle, then go to `IDLE`.

Bus and client rules:
- `ram.address`, `ram.we`, `ram.data_write` and `ram.wm` are registered. They are stable from `ISSUE` through the `ram.ack` cycle.
- `ram.ack` arriving in any state other than `WAIT` is ignored.
- `req` while `busy`=1 is dropped: no queueing, and `overrun` is set. `req` in the same cycle that `ack`=1 is also dropped, because `busy` is still high.
- `reset` mid-operation: return to `IDLE`, deassert all outputs, invalidate the cache. A late `ram.ack` is discarded.
- Reset values: `rdata`=0, `ack`=0, `busy`=0, `overrun`=0, `ram.req`=0, `ram.we`=0, `ram.address`=0, `ram.data_write`=0, `ram.wm`=2'b00, cache invalid.
- SDRAM refresh is invisible to this block; it only stretches `WAIT`.

## Timing
- Cache-hit read: `req` at cycle N, `ack` and `rdata` at N+1; no `ram.req` is issued.
- Miss or write: `req` at N, `ram.req` at N+1, `ram.ack` at M ≥ N+2, `ack` at M+1.
- Back-to-back throughput: the next `req` is accepted at the earliest in the cycle after `ack`.
- `flush` has priority over a same-cycle cache fill. A read completing in the same cycle as `flush` returns correct data but leaves the cache invalid.

## Configuration
- `SDRAM_BYTE_PORT_CACHE_EN` defined:
  - One-word read cache holding a tag (word address), 16-bit data and a valid bit.
  - Every read miss fills the cache from `ram.data_read`.
  - A write to the cached word updates that byte lane in the cache (write-through; the SDRAM write is still issued).
  - `flush` clears the valid bit.
- Undefined: every read goes to SDRAM, `flush` is ignored, and no cache registers are synthesized.

## Structure
- Shared package `sdram_pkg` holds:
  - the state typedef `byte_port_state_t`;
  - the lane write-mask constants `WM_LANE0`=2'b10, `WM_LANE1`=2'b01, `WM_NONE`=2'b00.
- Sub-module `byte_port_cache`:
  - tag/data/valid registers;
  - inputs: hit compare, fill, lane update and flush;
  - instantiated only under the macro.

## Test plan
- Write 0xA5 to byte 0x000010, then 0x3C to byte 0x000011:
  - `ram.wm` = 10 then 01;
  - a following read of byte 0x10 returns 0xA5 and of byte 0x11 returns 0x3C.
- Read miss of byte 0x000021 after a word write of 0xBEEF to word 0x10:
  - `rdata`=0xBE;
  - exactly one `ram.req` per access.
- With the cache enabled, read 0x21 then 0x20:
  - second `ack` arrives one cycle after `req` with `rdata`=0xEF;
  - zero `ram.req` on the second read.
- Cache write-through and flush:
  - write 0x55 to 0x20, then read 0x20 → 0x55 with no `ram.req`;
  - pulse `flush`, then read 0x20 → `ram.req` is issued.
- Assert `req` during `WAIT`:
  - the request is dropped and `overrun`=1;
  - the original request still acks.
- Assert `reset` during `WAIT`:
  - `busy`=0 the next cycle;
  - a late `ram.ack` produces no `ack`;
  - a subsequent read misses.
